pong_game_ctrl: RTL and testbench

//  Frame-rate game sequencer for the pong datapath. Owns ball and paddle positions, ball velocity, scores
//  and the game state machine; the pixel generator only renders them. Advances once per ref_tick (60 Hz,

---
 rtl/pong_game_ctrl_pkg.sv | 45 ++++
 rtl/pong_paddle.sv | 31 +++
 rtl/pong_game_ctrl.sv | 174 +++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_game_ctrl_pkg.sv
// Shared pong constants: screen, ball and paddle geometry plus game state encodings,
// imported by the game controller and the pixel generator so both agree on every value.
package pong_game_ctrl_pkg;

  localparam int H_ACTIVE     = 640;
  localparam int V_ACTIVE     = 480;
  localparam int BALL_SZ      = 8;
  localparam int PAD_W        = 4;
  localparam int PAD_H        = 64;
  localparam int PAD_L_X      = 32;
  localparam int PAD_R_X      = 604;
  localparam int PAD_SPEED    = 4;
  localparam int CPU_SPEED    = 3;
  localparam int BALL_SPEED   = 2;
  localparam int SERVE_FRAMES = 60;
  localparam int POINT_FRAMES = 90;
  localparam int WIN_SCORE    = 7;

  localparam logic [9:0] BALL_X0   = 10'((H_ACTIVE - BALL_SZ) / 2);
  localparam logic [9:0] BALL_Y0   = 10'((V_ACTIVE - BALL_SZ) / 2);
  localparam logic [9:0] PAD_Y0    = 10'((V_ACTIVE - PAD_H) / 2);
  localparam logic [9:0] PAD_Y_MAX = 10'(V_ACTIVE - PAD_H);

  // Signed 11-bit geometry so the next ball position may go negative before clamping.
  localparam logic signed [10:0] L_FACE = 11'(PAD_L_X + PAD_W);
  localparam logic signed [10:0] R_FACE = 11'(PAD_R_X - BALL_SZ);
  localparam logic signed [10:0] X_MAX  = 11'(H_ACTIVE - BALL_SZ);
  localparam logic signed [10:0] Y_MAX  = 11'(V_ACTIVE - BALL_SZ);
  localparam logic signed [10:0] BALL_S = 11'(BALL_SZ);
  localparam logic signed [10:0] PAD_HS = 11'(PAD_H);
  localparam logic signed [10:0] BALL_V = 11'(BALL_SPEED);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } game_state_t;

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s == 4'hF) ? s : s + 4'd1;
  endfunction

endpackage

// File: rtl/pong_paddle.sv
// One paddle: a top-edge register stepping up or down by `step` per enabled frame,
// clamped to the visible area; `clear` recentres it.
module pong_paddle
  import pong_game_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       clear,
  input  logic       up,
  input  logic       down,
  input  logic [3:0] step,
  output logic [9:0] y
);

  logic [10:0] y_dn;

  assign y_dn = {1'b0, y} + {7'd0, step};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y <= PAD_Y0;
    end else if (clear) begin
      y <= PAD_Y0;
    end else if (enable && (up != down)) begin
      if (up) y <= (y < {6'd0, step}) ? 10'd0 : y - {6'd0, step};
      else    y <= (y_dn > {1'b0, PAD_Y_MAX}) ? PAD_Y_MAX : y_dn[9:0];
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Frame-rate pong sequencer: game FSM, ball motion and collisions, scores and paddles.
// Every register advances only on ref_tick so the renderer sees one stable frame.
module pong_game_ctrl
  import pong_game_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ref_tick,
  input  logic       up,
  input  logic       down,
  input  logic       mode,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] pad_l_y,
  output logic [9:0] pad_r_y,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [2:0] game_state
);

  game_state_t state, state_nx;
  logic [6:0]  frame_cnt, frame_cnt_nx;
  logic [9:0]  ball_x_nx, ball_y_nx;
  logic [3:0]  score_l_nx, score_r_nx;
  logic        vx_neg, vx_neg_nx, vy_neg, vy_neg_nx;
  logic        serve_right, serve_right_nx, mode_q, mode_q_nx;
  logic        pad_move, pad_clear, cpu_up, cpu_down, hit;
  logic signed [10:0] bx, by, nx, ny, pl, pr;
  logic [10:0] pad_c, ball_c;

  assign game_state = state;
  assign pad_move   = ref_tick && (state == ST_SERVE || state == ST_PLAY);
  assign pad_clear  = ref_tick && (state == ST_OVER) && up && down;

  // CPU steers its paddle centre toward the ball centre with a +/-2 px dead band.
  assign pad_c    = {1'b0, pad_r_y} + 11'(PAD_H / 2);
  assign ball_c   = {1'b0, ball_y} + 11'(BALL_SZ / 2);
  assign cpu_down = (pad_c + 11'd2) < ball_c;
  assign cpu_up   = pad_c > (ball_c + 11'd2);

  pong_paddle u_pad_l (
    .clk(clk), .rst(rst), .enable(pad_move), .clear(pad_clear),
    .up(up), .down(down), .step(4'(PAD_SPEED)), .y(pad_l_y)
  );

  pong_paddle u_pad_r (
    .clk(clk), .rst(rst), .enable(pad_move && mode_q), .clear(pad_clear),
    .up(cpu_up), .down(cpu_down), .step(4'(CPU_SPEED)), .y(pad_r_y)
  );

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no branch can infer a latch.
    state_nx       = state;
    frame_cnt_nx   = frame_cnt + 7'd1;
    ball_x_nx      = ball_x;
    ball_y_nx      = ball_y;
    vx_neg_nx      = vx_neg;
    vy_neg_nx      = vy_neg;
    serve_right_nx = serve_right;
    mode_q_nx      = mode_q;
    score_l_nx     = score_l;
    score_r_nx     = score_r;
    hit            = 1'b0;
    bx = {1'b0, ball_x};
    by = {1'b0, ball_y};
    pl = {1'b0, pad_l_y};
    pr = {1'b0, pad_r_y};
    nx = vx_neg ? bx - BALL_V : bx + BALL_V;
    ny = vy_neg ? by - BALL_V : by + BALL_V;

    case (state)
      ST_IDLE: begin
        if (up || down) begin
          mode_q_nx = mode;
          state_nx  = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (frame_cnt == 7'(SERVE_FRAMES - 1)) begin
          state_nx  = ST_PLAY;
          vx_neg_nx = !serve_right;
          vy_neg_nx = 1'b0;
        end
      end
      ST_PLAY: begin
        if (ny <= 11'sd0) begin
          ny = '0;
          vy_neg_nx = 1'b0;
        end else if (ny >= Y_MAX) begin
          ny = Y_MAX;
          vy_neg_nx = 1'b1;
        end
        if (vx_neg && bx >= L_FACE && nx < L_FACE && ny + BALL_S > pl && ny < pl + PAD_HS) begin
          nx = L_FACE;
          vx_neg_nx = 1'b0;
          hit = 1'b1;
        end
        if (mode_q && !vx_neg && bx <= R_FACE && nx > R_FACE && ny + BALL_S > pr && ny < pr + PAD_HS) begin
          nx = R_FACE;
          vx_neg_nx = 1'b1;
          hit = 1'b1;
        end
        if (!mode_q && nx >= X_MAX) begin
          nx = X_MAX;
          vx_neg_nx = 1'b1;
        end
        // A paddle hit in this frame overrides any miss test.
        if (!hit && nx <= 11'sd0) begin
          nx = '0;
          score_r_nx     = sat_inc(score_r);
          serve_right_nx = 1'b1;
          state_nx       = ST_POINT;
        end else if (!hit && mode_q && nx >= X_MAX) begin
          nx = X_MAX;
          score_l_nx     = sat_inc(score_l);
          serve_right_nx = 1'b0;
          state_nx       = ST_POINT;
        end
        ball_x_nx = nx[9:0];
        ball_y_nx = ny[9:0];
      end
      ST_POINT: begin
        if (frame_cnt == 7'(POINT_FRAMES - 1)) begin
          if (score_l == 4'(WIN_SCORE) || score_r == 4'(WIN_SCORE)) begin
            state_nx = ST_OVER;
          end else begin
            state_nx  = ST_SERVE;
            ball_x_nx = BALL_X0;
            ball_y_nx = BALL_Y0;
          end
        end
      end
      ST_OVER: begin
        if (up && down) begin
          state_nx   = ST_IDLE;
          score_l_nx = '0;
          score_r_nx = '0;
          ball_x_nx  = BALL_X0;
          ball_y_nx  = BALL_Y0;
        end
      end
      default: state_nx = ST_IDLE;
    endcase

    if (state_nx != state) frame_cnt_nx = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      frame_cnt   <= '0;
      ball_x      <= BALL_X0;
      ball_y      <= BALL_Y0;
      vx_neg      <= 1'b1;
      vy_neg      <= 1'b0;
      serve_right <= 1'b0;
      mode_q      <= 1'b0;
      score_l     <= '0;
      score_r     <= '0;
    end else if (ref_tick) begin
      state       <= state_nx;
      frame_cnt   <= frame_cnt_nx;
      ball_x      <= ball_x_nx;
      ball_y      <= ball_y_nx;
      vx_neg      <= vx_neg_nx;
      vy_neg      <= vy_neg_nx;
      serve_right <= serve_right_nx;
      mode_q      <= mode_q_nx;
      score_l     <= score_l_nx;
      score_r     <= score_r_nx;
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl: a behavioural game model predicts every frame,
// expectations are queued when a tick is driven and compared once the DUT has updated.
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, ref_tick, up, down, mode;
  logic [9:0] ball_x, ball_y, pad_l_y, pad_r_y;
  logic [3:0] score_l, score_r;
  logic [2:0] game_state;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int st, bx, by, pl, pr, sl, sr;
  } snap_t;
  snap_t exp_q[$];

  // Behavioural model state.
  int m_state, m_cnt, m_bx, m_by, m_vx, m_vy, m_pl, m_pr, m_sl, m_sr, m_serve_r, m_mode;

  pong_game_ctrl dut (
    .clk(clk), .rst(rst_n), .ref_tick(ref_tick), .up(up), .down(down), .mode(mode),
    .ball_x(ball_x), .ball_y(ball_y), .pad_l_y(pad_l_y), .pad_r_y(pad_r_y),
    .score_l(score_l), .score_r(score_r), .game_state(game_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_bx = 316; m_by = 236; m_vx = -2; m_vy = 2;
    m_pl = 208; m_pr = 208; m_sl = 0; m_sr = 0; m_serve_r = 0; m_mode = 0;
  endtask

  function automatic int sat15(input int v);
    return (v >= 15) ? 15 : v + 1;
  endfunction

  task automatic model_step(input logic u, input logic d, input logic m);
    int nx, ny, pl0, pr0;
    bit hit;
    pl0 = m_pl;
    pr0 = m_pr;
    if (m_state == 1 || m_state == 2) begin
      if (u && !d)      m_pl = (m_pl - 4 < 0)   ? 0   : m_pl - 4;
      else if (d && !u) m_pl = (m_pl + 4 > 416) ? 416 : m_pl + 4;
      if (m_mode != 0) begin
        if (pr0 + 32 < m_by + 4 - 2)      m_pr = (pr0 + 3 > 416) ? 416 : pr0 + 3;
        else if (pr0 + 32 > m_by + 4 + 2) m_pr = (pr0 - 3 < 0)   ? 0   : pr0 - 3;
      end
    end
    case (m_state)
      0: if (u || d) begin m_mode = int'(m); m_state = 1; m_cnt = 0; end
      1: begin
        if (m_cnt == 59) begin
          m_state = 2; m_cnt = 0; m_vx = (m_serve_r != 0) ? 2 : -2; m_vy = 2;
        end else m_cnt++;
      end
      2: begin
        nx = m_bx + m_vx;
        ny = m_by + m_vy;
        hit = 0;
        if (ny <= 0) begin ny = 0; m_vy = 2; end
        else if (ny >= 472) begin ny = 472; m_vy = -2; end
        if (m_vx < 0 && m_bx >= 36 && nx < 36 && ny + 8 > pl0 && ny < pl0 + 64) begin
          nx = 36; hit = 1;
        end else if (m_mode != 0 && m_vx > 0 && m_bx <= 596 && nx > 596 && ny + 8 > pr0 && ny < pr0 + 64) begin
          nx = 596; hit = 1;
        end
        if (hit) m_vx = -m_vx;
        else if (m_mode == 0 && nx >= 632) begin nx = 632; m_vx = -2; end
        else if (nx <= 0) begin
          nx = 0; m_sr = sat15(m_sr); m_serve_r = 1; m_state = 3; m_cnt = 0;
        end else if (m_mode != 0 && nx >= 632) begin
          nx = 632; m_sl = sat15(m_sl); m_serve_r = 0; m_state = 3; m_cnt = 0;
        end
        m_bx = nx;
        m_by = ny;
      end
      3: begin
        if (m_cnt == 89) begin
          m_cnt = 0;
          if (m_sl == 7 || m_sr == 7) m_state = 4;
          else begin m_state = 1; m_bx = 316; m_by = 236; end
        end else m_cnt++;
      end
      4: begin
        if (u && d) begin
          m_state = 0; m_sl = 0; m_sr = 0; m_bx = 316; m_by = 236; m_pl = 208; m_pr = 208;
        end
      end
      default: ;
    endcase
  endtask

  task automatic push_model();
    snap_t s;
    s.st = m_state; s.bx = m_bx; s.by = m_by; s.pl = m_pl;
    s.pr = m_pr; s.sl = m_sl; s.sr = m_sr;
    exp_q.push_back(s);
  endtask

  task automatic score_front(input string tag);
    snap_t e;
    if (exp_q.size() == 0) begin
      check({tag, ".queue_empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      check({tag, ".state"}, 32'(game_state), e.st);
      check({tag, ".ball_x"}, 32'(ball_x), e.bx);
      check({tag, ".ball_y"}, 32'(ball_y), e.by);
      check({tag, ".pad_l_y"}, 32'(pad_l_y), e.pl);
      check({tag, ".pad_r_y"}, 32'(pad_r_y), e.pr);
      check({tag, ".score_l"}, 32'(score_l), e.sl);
      check({tag, ".score_r"}, 32'(score_r), e.sr);
    end
  endtask

  // One frame: a quiet clock, then a single-clock ref_tick pulse, then the comparison.
  task automatic tick(input logic u, input logic d, input logic m, input string tag);
    @(negedge clk);
    @(negedge clk);
    up = u; down = d; mode = m; ref_tick = 1'b1;
    model_step(u, d, m);
    push_model();
    @(posedge clk);
    #1;
    ref_tick = 1'b0;
    score_front(tag);
  endtask

  // pol 0 tracks the ball with the left paddle, pol 1 dodges it.
  task automatic pick(input int pol, output logic u, output logic d);
    u = 1'b0;
    d = 1'b0;
    if (pol == 0) begin
      if (m_pl + 32 < m_by + 4 - 4)      d = 1'b1;
      else if (m_pl + 32 > m_by + 4 + 4) u = 1'b1;
    end else begin
      if (m_by < 240) d = 1'b1;
      else            u = 1'b1;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".state"}, 32'(game_state), 0);
    check({tag, ".ball_x"}, 32'(ball_x), 316);
    check({tag, ".ball_y"}, 32'(ball_y), 236);
    check({tag, ".pad_l_y"}, 32'(pad_l_y), 208);
    check({tag, ".pad_r_y"}, 32'(pad_r_y), 208);
    check({tag, ".score_l"}, 32'(score_l), 0);
    check({tag, ".score_r"}, 32'(score_r), 0);
  endtask

  initial begin
    logic u, d;
    rst_n = 1'b0; ref_tick = 1'b0; up = 1'b0; down = 1'b0; mode = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Inputs without ref_tick must not move anything.
    up = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    push_model();
    score_front("no_tick");
    up = 1'b0;

    // Game 1, wall mode: start, hold both buttons for a while, then wait out the serve.
    tick(1'b1, 1'b0, 1'b0, "start1");
    check("start1.serve", 32'(game_state), 1);
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b1, 1'b0, "both_held");
      check("both_held.pad", 32'(pad_l_y), 208);
    end
    for (int i = 0; i < 48; i++) tick(1'b0, 1'b0, 1'b0, "serve");
    tick(1'b0, 1'b0, 1'b0, "tick60");
    check("tick60.state", 32'(game_state), 1);
    tick(1'b0, 1'b0, 1'b0, "tick61");
    check("tick61.state", 32'(game_state), 2);
    check("tick61.bx", 32'(ball_x), 316);
    check("tick61.by", 32'(ball_y), 236);
    tick(1'b0, 1'b0, 1'b0, "tick62");
    check("tick62.bx", 32'(ball_x), 314);
    check("tick62.by", 32'(ball_y), 238);

    // Tracking paddle: rally with paddle and wall bounces, nobody scores.
    for (int i = 0; i < 600; i++) begin
      pick(0, u, d);
      tick(u, d, 1'b0, "track");
    end
    check("track.score_r", 32'(score_r), 0);
    check("track.state", 32'(game_state), 2);

    // Asynchronous reset in the middle of play.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    push_model();
    score_front("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;

    // Game 2, CPU mode: hold up 200 frames from the start, paddle pins at the top.
    tick(1'b1, 1'b0, 1'b1, "start2");
    for (int i = 0; i < 199; i++) tick(1'b1, 1'b0, 1'b1, "hold_up");
    check("hold_up.pad", 32'(pad_l_y), 0);
    check("hold_up.state", 32'(game_state), 2);

    // Dodge the ball until the CPU side wins; mode input is ignored from here on.
    for (int i = 0; i < 8000 && m_state != 4; i++) begin
      pick(1, u, d);
      tick(u, d, 1'b0, "dodge");
    end
    check("over.state", 32'(game_state), 4);
    check("over.score_r", 32'(score_r), 7);

    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, "over_idle");
    tick(1'b1, 1'b0, 1'b0, "over_up_only");
    check("over_up_only.state", 32'(game_state), 4);
    tick(1'b1, 1'b1, 1'b0, "restart");
    check_reset_values("restart");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
